// File: rtl/adc_trigger_threshold_comp.sv
// -----------------------------------------------------------------------------
// adc_trigger_threshold_comp
//
// Purpose:
//   Front end of the trigger core. Turns raw ADC samples on channels A and B
//   into four qualified comparator levels (A-hi, A-lo, B-hi, B-lo). Each valid
//   sample is compared against the active high/low thresholds. A level asserts
//   only after a run of consecutive qualifying samples (glitch rejection), and
//   it stays asserted while the condition persists.
//
//   Timing: a sample captured with valid on edge N affects the outputs after
//   edge N+2. Stage 1 registers the sample. Stage 2 holds it while the
//   comparator FSMs consume it.
//
// Optional feature:
//   ADC_TRIGGER_THRESH_HYST_EN - when defined, adds the thresh_hyst input.
//   An asserted hi level then releases only below sat(hi - hyst), and an
//   asserted lo level releases only above sat(lo + hyst).
//
// Ports:
//   adc_data_clk     sole clock
//   comp_rst_n       asynchronous active-low reset
//   comp_ena         enable; low forces all comparators to CLR
//   adc_data_valid   samples valid this cycle
//   adc_a_data       channel A sample
//   adc_b_data       channel B sample
//   thresh_hi        high threshold, captured on thresh_load
//   thresh_lo        low threshold, captured on thresh_load
//   thresh_hyst      hysteresis, captured on thresh_load (feature build only)
//   thresh_load      single-cycle strobe that loads the active thresholds
//   qual_count       extra consecutive samples required (read live)
//   adc_a_hi_comp    qualified channel A >= hi
//   adc_a_lo_comp    qualified channel A <= lo
//   adc_b_hi_comp    qualified channel B >= hi
//   adc_b_lo_comp    qualified channel B <= lo
//   thresh_err       registered flag: active lo > active hi
// -----------------------------------------------------------------------------
module adc_trigger_threshold_comp #(
    parameter int ADC_BITS  = 8,
    parameter int QUAL_BITS = 4
) (
    input  logic                 adc_data_clk,
    input  logic                 comp_rst_n,
    input  logic                 comp_ena,
    input  logic                 adc_data_valid,
    input  logic [ADC_BITS-1:0]  adc_a_data,
    input  logic [ADC_BITS-1:0]  adc_b_data,
    input  logic [ADC_BITS-1:0]  thresh_hi,
    input  logic [ADC_BITS-1:0]  thresh_lo,
`ifdef ADC_TRIGGER_THRESH_HYST_EN
    input  logic [ADC_BITS-1:0]  thresh_hyst,
`endif
    input  logic                 thresh_load,
    input  logic [QUAL_BITS-1:0] qual_count,
    output logic                 adc_a_hi_comp,
    output logic                 adc_a_lo_comp,
    output logic                 adc_b_hi_comp,
    output logic                 adc_b_lo_comp,
    output logic                 thresh_err
);

    typedef enum logic [1:0] {
        ST_CLR  = 2'd0,
        ST_QUAL = 2'd1,
        ST_ACT  = 2'd2
    } comp_state_e;

    // Two-stage sample pipeline. It keeps running while comp_ena is low.
    logic [ADC_BITS-1:0] a_s1_q, b_s1_q, a_s2_q, b_s2_q;
    logic                vld_s1_q, vld_s2_q;

    // Active thresholds and the registered error flag.
    logic [ADC_BITS-1:0] hi_act_q, lo_act_q;
    logic                thresh_err_q;

    always_ff @(posedge adc_data_clk or negedge comp_rst_n) begin
        if (!comp_rst_n) begin
            a_s1_q       <= '0;
            b_s1_q       <= '0;
            a_s2_q       <= '0;
            b_s2_q       <= '0;
            vld_s1_q     <= 1'b0;
            vld_s2_q     <= 1'b0;
            hi_act_q     <= '1;
            lo_act_q     <= '0;
            thresh_err_q <= 1'b0;
        end else begin
            a_s1_q       <= adc_a_data;
            b_s1_q       <= adc_b_data;
            vld_s1_q     <= adc_data_valid;
            a_s2_q       <= a_s1_q;
            b_s2_q       <= b_s1_q;
            vld_s2_q     <= vld_s1_q;
            thresh_err_q <= (lo_act_q > hi_act_q);
            if (thresh_load) begin
                hi_act_q <= thresh_hi;
                lo_act_q <= thresh_lo;
            end
        end
    end

    // The FSMs are gated with the live compare rather than thresh_err_q.
    // The flag lags a bad load by one cycle. Gating on the live compare
    // prevents a sample in that cycle from briefly asserting an output.
    logic thr_bad;
    logic force_clr;
    assign thr_bad   = (lo_act_q > hi_act_q);
    assign force_clr = thresh_load | ~comp_ena | thr_bad;

    // Release levels for an asserted comparator.
    logic [ADC_BITS-1:0] hi_rel_lvl, lo_rel_lvl;
`ifdef ADC_TRIGGER_THRESH_HYST_EN
    logic [ADC_BITS-1:0] hyst_q;
    logic [ADC_BITS:0]   lo_plus_hyst;

    always_ff @(posedge adc_data_clk or negedge comp_rst_n) begin
        if (!comp_rst_n) begin
            hyst_q <= '0;
        end else if (thresh_load) begin
            hyst_q <= thresh_hyst;
        end
    end

    assign lo_plus_hyst = {1'b0, lo_act_q} + {1'b0, hyst_q};
    assign hi_rel_lvl   = (hi_act_q >= hyst_q) ? (hi_act_q - hyst_q) : '0;
    assign lo_rel_lvl   = lo_plus_hyst[ADC_BITS] ? '1 : lo_plus_hyst[ADC_BITS-1:0];
`else
    assign hi_rel_lvl = hi_act_q;
    assign lo_rel_lvl = lo_act_q;
`endif

    // Comparator index: 0 = A-hi, 1 = A-lo, 2 = B-hi, 3 = B-lo.
    logic [3:0] act_vec;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_comp
            localparam bit IS_B  = (gi >= 2);
            localparam bit IS_LO = ((gi % 2) == 1);

            comp_state_e          state_q, state_d;
            logic [QUAL_BITS-1:0] cnt_q, cnt_d;
            logic [QUAL_BITS-1:0] cnt_sat;
            logic [QUAL_BITS:0]   cnt_plus1;
            logic [ADC_BITS-1:0]  smp;
            logic                 qual_hit;
            logic                 act_exit;

            assign smp = IS_B ? b_s2_q : a_s2_q;

            // Equality qualifies in both directions.
            assign qual_hit = IS_LO ? (smp <= lo_act_q) : (smp >= hi_act_q);

            // With zero hysteresis the release condition is exactly !qual_hit.
            assign act_exit = IS_LO ? (smp > lo_rel_lvl) : (smp < hi_rel_lvl);

            // The run counter saturates instead of wrapping. A wrap would
            // let a long run fall back below qual_count.
            assign cnt_sat   = (&cnt_q) ? cnt_q : (cnt_q + QUAL_BITS'(1));
            assign cnt_plus1 = {1'b0, cnt_q} + (QUAL_BITS + 1)'(1);

            always_ff @(posedge adc_data_clk or negedge comp_rst_n) begin
                if (!comp_rst_n) begin
                    state_q <= ST_CLR;
                    cnt_q   <= '0;
                end else begin
                    state_q <= state_d;
                    cnt_q   <= cnt_d;
                end
            end

            always_comb begin
                state_d = state_q;
                cnt_d   = cnt_q;
                if (force_clr) begin
                    state_d = ST_CLR;
                    cnt_d   = '0;
                end else if (vld_s2_q) begin
                    case (state_q)
                        ST_CLR: begin
                            if (qual_hit) begin
                                cnt_d   = QUAL_BITS'(1);
                                state_d = (qual_count == '0) ? ST_ACT : ST_QUAL;
                            end
                        end
                        ST_QUAL: begin
                            if (qual_hit) begin
                                cnt_d = cnt_sat;
                                // qual_count is read live. Lowering it below
                                // the current run promotes on the next hit.
                                if (cnt_plus1 > {1'b0, qual_count}) begin
                                    state_d = ST_ACT;
                                end
                            end else begin
                                state_d = ST_CLR;
                                cnt_d   = '0;
                            end
                        end
                        ST_ACT: begin
                            if (act_exit) begin
                                state_d = ST_CLR;
                                cnt_d   = '0;
                            end else if (qual_hit) begin
                                cnt_d = cnt_sat;
                            end
                        end
                        default: begin
                            state_d = ST_CLR;
                            cnt_d   = '0;
                        end
                    endcase
                end
            end

            assign act_vec[gi] = (state_q == ST_ACT);
        end
    endgenerate

    assign adc_a_hi_comp = act_vec[0];
    assign adc_a_lo_comp = act_vec[1];
    assign adc_b_hi_comp = act_vec[2];
    assign adc_b_lo_comp = act_vec[3];
    assign thresh_err    = thresh_err_q;

endmodule

// File: tb/tb_adc_trigger_threshold_comp.sv
// -----------------------------------------------------------------------------
// tb_adc_trigger_threshold_comp
//
// Directed testbench for adc_trigger_threshold_comp. Inputs change 1 time unit
// after each rising edge. Outputs are sampled at that same point, so each
// check sees the state left by the edge just taken.
//
// Latency used below: a sample captured on edge N affects the outputs after
// edge N+2. When valid is low, the comparator state holds.
// -----------------------------------------------------------------------------
module tb_adc_trigger_threshold_comp;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ena;
    logic       vld;
    logic [7:0] a_d, b_d, thi, tlo;
    logic       tld;
    logic [3:0] qc;
`ifdef ADC_TRIGGER_THRESH_HYST_EN
    logic [7:0] thy;
`endif
    logic       a_hi, a_lo, b_hi, b_lo, terr;

    int tests_run = 0;
    int fail_cnt  = 0;

    always #5 clk = ~clk;

    adc_trigger_threshold_comp #(
        .ADC_BITS (8),
        .QUAL_BITS(4)
    ) dut (
        .adc_data_clk  (clk),
        .comp_rst_n    (rst_n),
        .comp_ena      (ena),
        .adc_data_valid(vld),
        .adc_a_data    (a_d),
        .adc_b_data    (b_d),
        .thresh_hi     (thi),
        .thresh_lo     (tlo),
`ifdef ADC_TRIGGER_THRESH_HYST_EN
        .thresh_hyst   (thy),
`endif
        .thresh_load   (tld),
        .qual_count    (qc),
        .adc_a_hi_comp (a_hi),
        .adc_a_lo_comp (a_lo),
        .adc_b_hi_comp (b_hi),
        .adc_b_lo_comp (b_lo),
        .thresh_err    (terr)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            fail_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            $display("[TB] ok   %s = %0h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one valid sample pair for exactly one edge.
    task automatic smp(input logic [7:0] da, input logic [7:0] db);
        vld = 1'b1;
        a_d = da;
        b_d = db;
        tick();
        vld = 1'b0;
    endtask

    task automatic idle(input int n);
        vld = 1'b0;
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic load(input logic [7:0] h, input logic [7:0] l);
        thi = h;
        tlo = l;
        tld = 1'b1;
        vld = 1'b0;
        tick();
        tld = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    logic [7:0] seq2 [7];

    initial begin
        rst_n = 1'b0; ena = 1'b0; vld = 1'b0; tld = 1'b0; qc = 4'd0;
        a_d = 8'h00; b_d = 8'h00; thi = 8'h00; tlo = 8'h00;
`ifdef ADC_TRIGGER_THRESH_HYST_EN
        thy = 8'h00;
`endif
        seq2 = '{8'h90, 8'h90, 8'h90, 8'h10, 8'h90, 8'h90, 8'h90};

        // Reset state.
        tick(); tick();
        check_eq("rst a_hi", a_hi, 0);
        check_eq("rst a_lo", a_lo, 0);
        check_eq("rst b_hi", b_hi, 0);
        check_eq("rst b_lo", b_lo, 0);
        check_eq("rst err", terr, 0);
        rst_n = 1'b1; ena = 1'b1;
        tick();

        // Reset thresholds are hi=FF, lo=00; equality qualifies at both ends.
        smp(8'h00, 8'hFF); idle(2);
        check_eq("rstthr a_lo", a_lo, 1);
        check_eq("rstthr b_hi", b_hi, 1);
        check_eq("rstthr a_hi", a_hi, 0);
        check_eq("rstthr b_lo", b_lo, 0);

        // Test 1: hi=80, lo=40, qual=0, exact latency.
        load(8'h80, 8'h40);
        check_eq("t1 load clr a_lo", a_lo, 0);
        check_eq("t1 load clr b_hi", b_hi, 0);
        check_eq("t1 err", terr, 0);
        smp(8'h80, 8'h50);
        check_eq("t1 a_hi N", a_hi, 0);
        smp(8'h7F, 8'h50);
        check_eq("t1 a_hi N+1", a_hi, 0);
        idle(1);
        check_eq("t1 a_hi N+2", a_hi, 1);
        idle(1);
        check_eq("t1 a_hi drop", a_hi, 0);

        // Test 2: qual=3 needs four consecutive valid hits.
        qc = 4'd3;
        for (int i = 0; i < 7; i++) smp(seq2[i], 8'h50);
        idle(2);
        check_eq("t2 three hits", a_hi, 0);
        check_eq("t2 a_lo single", a_lo, 0);
        smp(8'h90, 8'h50); idle(1);
        check_eq("t2 fourth lat", a_hi, 0);
        idle(1);
        check_eq("t2 fourth hit", a_hi, 1);
        // Same count with valid gaps in between.
        smp(8'h10, 8'h50); idle(2);
        check_eq("t2g clear", a_hi, 0);
        smp(8'h90, 8'h50); idle(1);
        smp(8'h90, 8'h50); idle(2);
        smp(8'h90, 8'h50); idle(2);
        check_eq("t2g three hits", a_hi, 0);
        smp(8'h90, 8'h50); idle(1);
        check_eq("t2g fourth lat", a_hi, 0);
        idle(1);
        check_eq("t2g fourth hit", a_hi, 1);

        // Test 3: both lo comparators together, equality on A.
        qc = 4'd0;
        smp(8'h40, 8'h30); idle(1);
        check_eq("t3 a_lo early", a_lo, 0);
        check_eq("t3 b_lo early", b_lo, 0);
        idle(1);
        check_eq("t3 a_lo", a_lo, 1);
        check_eq("t3 b_lo", b_lo, 1);
        check_eq("t3 a_hi", a_hi, 0);
        check_eq("t3 b_hi", b_hi, 0);

        // Test 4: a load with inverted thresholds blocks all outputs.
        smp(8'hFF, 8'hFF); idle(2);
        check_eq("t4 pre a_hi", a_hi, 1);
        check_eq("t4 pre b_hi", b_hi, 1);
        load(8'h20, 8'h60);
        check_eq("t4 load a_hi", a_hi, 0);
        check_eq("t4 load b_hi", b_hi, 0);
        check_eq("t4 err lag", terr, 0);
        for (int i = 0; i < 4; i++) smp(8'hFF, 8'hFF);
        idle(2);
        check_eq("t4 bad a_hi", a_hi, 0);
        check_eq("t4 bad b_hi", b_hi, 0);
        check_eq("t4 bad err", terr, 1);
        load(8'h80, 8'h40);
        smp(8'hFF, 8'hFF); idle(2);
        check_eq("t4 fix a_hi", a_hi, 1);
        check_eq("t4 fix err", terr, 0);

        // Test 5: one-cycle enable drop, then qual=2 needs three new hits.
        ena = 1'b0; tick();
        check_eq("t5 dis a_hi", a_hi, 0);
        check_eq("t5 dis b_hi", b_hi, 0);
        ena = 1'b1; qc = 4'd2;
        smp(8'hFF, 8'hFF); smp(8'hFF, 8'hFF); idle(2);
        check_eq("t5 two hits", a_hi, 0);
        smp(8'hFF, 8'hFF); idle(1);
        check_eq("t5 third lat", a_hi, 0);
        idle(1);
        check_eq("t5 third hit", a_hi, 1);

        // Live lowering of qual_count promotes QUAL on the next hit.
        smp(8'h00, 8'h00); idle(2);
        check_eq("lq clear", a_hi, 0);
        qc = 4'd15;
        for (int i = 0; i < 5; i++) smp(8'hFF, 8'h00);
        idle(2);
        check_eq("lq five hits", a_hi, 0);
        qc = 4'd2;
        smp(8'hFF, 8'h00); idle(2);
        check_eq("lq lowered", a_hi, 1);

        // Maximum qual_count: 16 hits, and the counter saturates at 15.
        smp(8'h00, 8'h00); idle(2);
        qc = 4'd15;
        for (int i = 0; i < 15; i++) smp(8'hFF, 8'h00);
        idle(2);
        check_eq("sat 15 hits", a_hi, 0);
        smp(8'hFF, 8'h00); idle(2);
        check_eq("sat 16 hits", a_hi, 1);
        smp(8'hFF, 8'h00); smp(8'hFF, 8'h00); idle(2);
        check_eq("sat hold", a_hi, 1);

        // Asynchronous reset mid-cycle also restores the thresholds.
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("arst a_hi", a_hi, 0);
        check_eq("arst err", terr, 0);
        tick();
        rst_n = 1'b1; qc = 4'd0;
        smp(8'h90, 8'h00); idle(2);
        check_eq("arst thr a_hi", a_hi, 0);
        check_eq("arst thr b_lo", b_lo, 1);

`ifdef ADC_TRIGGER_THRESH_HYST_EN
        // Test 6: hysteresis on the hi comparator.
        thy = 8'h10;
        load(8'h80, 8'h40);
        smp(8'h90, 8'h50); idle(2);
        check_eq("hy assert", a_hi, 1);
        smp(8'h75, 8'h50); idle(2);
        check_eq("hy band hold", a_hi, 1);
        smp(8'h6F, 8'h50); idle(2);
        check_eq("hy release", a_hi, 0);
        thy = 8'hFF;
        load(8'h80, 8'h40);
        smp(8'h90, 8'h50); idle(2);
        check_eq("hy sat assert", a_hi, 1);
        smp(8'h00, 8'h50); idle(2);
        check_eq("hy sat never", a_hi, 1);
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, fail_cnt);
        $finish;
    end

endmodule
